pdp8liotq: RTL and testbench

Parametrised multi-channel PDP-8/L IOT mailbox; the successor to the single-device TC08 interface. Decodes IOPs for NCHAN consecutive device codes and queues AC words written by the PDP-8/L into one shared request FIFO that the ARM drains. The ARM answers through per-channel reply registers that drive the PDP-8/L data bus, skip and interrupt lines. It sits between the PDP-8/L IO bus logic and the ARM register bus.

---
 rtl/pdp8liotq.sv | 180 ++++++++++++++++++
 tb/tb_pdp8liotq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pdp8liotq.sv
// rtl/pdp8liotq.sv - multi-channel PDP-8/L IOT mailbox with shared request FIFO (optional PDP8LIOTQ_OVERRUN_EN)
module pdp8liotq #(
    parameter int          NCHAN     = 4,
    parameter logic [5:0]  DEVBASE   = 6'o40,
    parameter int          DEPTHLOG2 = 4
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic        CSTEP,
    input  logic        BINIT,
    input  logic        armwrite,
    input  logic [3:0]  armraddr,
    input  logic [3:0]  armwaddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    input  logic        iopstart,
    input  logic        iopstop,
    input  logic [11:0] ioopcode,
    input  logic [11:0] cputodev,
    output logic [11:0] devtocpu,
    output logic        AC_CLEAR,
    output logic        IO_SKIP,
    output logic        INT_RQST
);
    localparam int                 DEPTH   = 1 << DEPTHLOG2;
    localparam logic [5:0]         NCHAN6  = 6'(NCHAN);
    localparam logic [3:0]         NCHAN4  = 4'(NCHAN);
    localparam logic [3:0]         DLOG4   = 4'(DEPTHLOG2);
    localparam logic [DEPTHLOG2:0] CNT_ONE = (DEPTHLOG2+1)'(1);
    localparam logic [DEPTHLOG2-1:0] PTR_ONE = DEPTHLOG2'(1);

    // Per-channel state is held for 8 channels so a 3-bit channel index is always in range;
    // channels at or above NCHAN are never written and stay zero.
    logic [11:0] reply_q [8];
    logic [11:0] reply_d [8];
    logic [7:0]  flag_q, flag_d, ienab_q, ienab_d, ovf_q, ovf_d, ovf_eff;
    logic        enable_q, enable_d;
    logic [11:0] devtocpu_q, devtocpu_d;
    logic        ac_clear_q, ac_clear_d, io_skip_q, io_skip_d;

    logic [14:0]          mem_q [DEPTH];
    logic [DEPTHLOG2-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [DEPTHLOG2:0]   count_q, count_d;

    logic [5:0] dev_off;
    logic [2:0] ichan, iop_p;
    logic       iop_acc, fifo_empty, fifo_full, pop_en, push_req, push_en;
    logic [3:0] wsub, rsub;
    logic       w_chan, r_chan;
    logic [2:0] wchan, rchan;
    logic       unused_wdata;

    assign dev_off  = ioopcode[8:3] - DEVBASE;
    assign ichan    = dev_off[2:0];
    assign iop_p    = ioopcode[2:0];
    assign iop_acc  = CSTEP & iopstart & enable_q & (ioopcode[11:9] == 3'o6) & (dev_off < NCHAN6);

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = count_q[DEPTHLOG2];
    assign pop_en     = ~BINIT & armwrite & (armwaddr == 4'd1) & ~fifo_empty;
    assign push_req   = iop_acc & iop_p[2];
    assign push_en    = ~BINIT & push_req & (~fifo_full | pop_en);

    assign wsub   = armwaddr - 4'd2;
    assign wchan  = wsub[2:0];
    assign w_chan = armwrite & (armwaddr >= 4'd2) & (wsub < NCHAN4);
    assign rsub   = armraddr - 4'd2;
    assign rchan  = rsub[2:0];
    assign r_chan = (armraddr >= 4'd2) & (rsub < NCHAN4);

    assign unused_wdata = ^armwdata[28:12];

`ifdef PDP8LIOTQ_OVERRUN_EN
    assign ovf_eff = ovf_q;
`else
    assign ovf_eff = '0;
`endif

    assign devtocpu = devtocpu_q;
    assign AC_CLEAR = ac_clear_q;
    assign IO_SKIP  = io_skip_q;
    assign INT_RQST = |(ienab_q & (flag_q | ovf_eff));

    // Next-state: bus init first, then IOP effects, then ARM writes so the ARM wins conflicts
    always_comb begin
        reply_d    = reply_q;
        flag_d     = flag_q;
        ienab_d    = ienab_q;
        ovf_d      = ovf_q;
        enable_d   = enable_q;
        devtocpu_d = devtocpu_q;
        ac_clear_d = ac_clear_q;
        io_skip_d  = io_skip_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (BINIT) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            flag_d     = '0;
            ovf_d      = '0;
            devtocpu_d = '0;
            ac_clear_d = 1'b0;
            io_skip_d  = 1'b0;
        end else begin
            if (iop_acc) begin
                if (iop_p[0]) io_skip_d = flag_q[ichan] | ovf_eff[ichan];
                if (iop_p[1]) begin
                    devtocpu_d    = reply_q[ichan];
                    flag_d[ichan] = 1'b0;
                end
                if (iop_p[2] & ~iop_p[1]) ac_clear_d = 1'b1;
`ifdef PDP8LIOTQ_OVERRUN_EN
                if (push_req & fifo_full & ~pop_en) ovf_d[ichan] = 1'b1;
`endif
            end else if (CSTEP & iopstop) begin
                devtocpu_d = '0;
                ac_clear_d = 1'b0;
                io_skip_d  = 1'b0;
            end
            if (push_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push_en & ~pop_en)      count_d = count_q + CNT_ONE;
            else if (pop_en & ~push_en) count_d = count_q - CNT_ONE;
            if (w_chan) begin
                reply_d[wchan] = armwdata[11:0];
                ienab_d[wchan] = armwdata[31];
                flag_d[wchan]  = armwdata[30];
                if (armwdata[29]) ovf_d[wchan] = 1'b0;
            end
            if (armwrite & (armwaddr == 4'd15)) enable_d = armwdata[31];
        end
    end

    // State registers with asynchronous reset; enable comes up set
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            reply_q    <= '{default: '0};
            flag_q     <= '0;
            ienab_q    <= '0;
            ovf_q      <= '0;
            enable_q   <= 1'b1;
            devtocpu_q <= '0;
            ac_clear_q <= 1'b0;
            io_skip_q  <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            reply_q    <= reply_d;
            flag_q     <= flag_d;
            ienab_q    <= ienab_d;
            ovf_q      <= ovf_d;
            enable_q   <= enable_d;
            devtocpu_q <= devtocpu_d;
            ac_clear_q <= ac_clear_d;
            io_skip_q  <= io_skip_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage; contents are don't-care while empty so no reset is needed
    always_ff @(posedge CLOCK) begin
        if (push_en) mem_q[wr_ptr_q] <= {ichan, cputodev};
    end

    // ARM register read mux
    always_comb begin
        armrdata = '0;
        case (armraddr)
            4'd0: armrdata = 32'h4951_3000 | {20'b0, DLOG4, 8'b0} | {28'b0, NCHAN4};
            4'd1: if (!fifo_empty) armrdata = {1'b1, 7'b0, 8'(count_q), 1'b0, mem_q[rd_ptr_q]};
            4'd15: armrdata = {enable_q, 31'b0};
            default: if (r_chan) armrdata = {ienab_q[rchan], flag_q[rchan], ovf_q[rchan], 1'b0, 16'b0, reply_q[rchan]};
        endcase
    end
endmodule

// File: tb/tb_pdp8liotq.sv
// tb/tb_pdp8liotq.sv - directed table-driven bench for pdp8liotq
module tb_pdp8liotq;
    logic        CLOCK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        CSTEP = 1'b0, BINIT = 1'b0, armwrite = 1'b0, iopstart = 1'b0, iopstop = 1'b0;
    logic [3:0]  armraddr = '0, armwaddr = '0;
    logic [31:0] armwdata = '0;
    logic [31:0] armrdata;
    logic [11:0] ioopcode = '0, cputodev = '0;
    logic [11:0] devtocpu;
    logic        AC_CLEAR, IO_SKIP, INT_RQST;

`ifdef PDP8LIOTQ_OVERRUN_EN
    localparam bit OVR = 1'b1;
`else
    localparam bit OVR = 1'b0;
`endif

    pdp8liotq dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .CSTEP(CSTEP), .BINIT(BINIT),
        .armwrite(armwrite), .armraddr(armraddr), .armwaddr(armwaddr),
        .armwdata(armwdata), .armrdata(armrdata), .iopstart(iopstart),
        .iopstop(iopstop), .ioopcode(ioopcode), .cputodev(cputodev),
        .devtocpu(devtocpu), .AC_CLEAR(AC_CLEAR), .IO_SKIP(IO_SKIP), .INT_RQST(INT_RQST)
    );

    always #5 CLOCK = ~CLOCK;

    int n_pass = 0;
    int n_total = 0;
    logic [14:0] fq[$];

    typedef struct {
        string       nm;
        logic        cs, st, sp;
        logic [11:0] op, ac;
        logic        aw;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  ra;
        logic [11:0] e_dev;
        logic        e_acc, e_skip, e_int;
        logic [31:0] e_rd;
    } vec_t;

    localparam int NV = 18;
    vec_t vt[NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step(input logic cs, st, sp, bi, input logic [11:0] op, ac,
                        input logic aw, input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] ra);
        @(negedge CLOCK);
        CSTEP = cs; iopstart = st; iopstop = sp; BINIT = bi;
        ioopcode = op; cputodev = ac;
        armwrite = aw; armwaddr = wa; armwdata = wd; armraddr = ra;
        @(posedge CLOCK);
        #1;
        CSTEP = 1'b0; iopstart = 1'b0; iopstop = 1'b0; BINIT = 1'b0; armwrite = 1'b0;
    endtask

    task automatic iop(input logic [11:0] op, ac, input logic [3:0] ra);
        step(1, 1, 0, 0, op, ac, 0, 4'd0, 32'h0, ra);
    endtask

    task automatic stop(input logic [3:0] ra);
        step(1, 0, 1, 0, 12'o0, 12'o0, 0, 4'd0, 32'h0, ra);
    endtask

    task automatic arm_wr(input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] ra);
        step(0, 0, 0, 0, 12'o0, 12'o0, 1, wa, wd, ra);
    endtask

    function automatic logic [31:0] head_word();
        if (fq.size() == 0) return 32'h0;
        return {1'b1, 7'b0, 8'(fq.size()), 1'b0, fq[0]};
    endfunction

    initial begin
        vt[0]  = '{"idle_id",   0,0,0, 12'o0,    12'o0,    0, 4'd0,  32'h0,         4'd0,  12'h000, 0,0,0, 32'h4951_3404};
        vt[1]  = '{"push6404",  1,1,0, 12'o6404, 12'o1234, 0, 4'd0,  32'h0,         4'd1,  12'h000, 1,0,0, 32'h8001_029C};
        vt[2]  = '{"stop1",     1,0,1, 12'o0,    12'o0,    0, 4'd0,  32'h0,         4'd1,  12'h000, 0,0,0, 32'h8001_029C};
        vt[3]  = '{"pop1",      0,0,0, 12'o0,    12'o0,    1, 4'd1,  32'h0,         4'd1,  12'h000, 0,0,0, 32'h0};
        vt[4]  = '{"wr_ch1",    0,0,0, 12'o0,    12'o0,    1, 4'd3,  32'hC000_0777, 4'd3,  12'h000, 0,0,1, 32'hC000_0777};
        vt[5]  = '{"skip6411",  1,1,0, 12'o6411, 12'o0,    0, 4'd0,  32'h0,         4'd3,  12'h000, 0,1,1, 32'hC000_0777};
        vt[6]  = '{"stop2",     1,0,1, 12'o0,    12'o0,    0, 4'd0,  32'h0,         4'd3,  12'h000, 0,0,1, 32'hC000_0777};
        vt[7]  = '{"read6412",  1,1,0, 12'o6412, 12'o0,    0, 4'd0,  32'h0,         4'd3,  12'h777, 0,0,0, 32'h8000_0777};
        vt[8]  = '{"stop3",     1,0,1, 12'o0,    12'o0,    0, 4'd0,  32'h0,         4'd3,  12'h000, 0,0,0, 32'h8000_0777};
        vt[9]  = '{"nodev6444", 1,1,0, 12'o6444, 12'o0001, 0, 4'd0,  32'h0,         4'd1,  12'h000, 0,0,0, 32'h0};
        vt[10] = '{"nocstep",   0,1,0, 12'o6404, 12'o0001, 0, 4'd0,  32'h0,         4'd1,  12'h000, 0,0,0, 32'h0};
        vt[11] = '{"disable",   0,0,0, 12'o0,    12'o0,    1, 4'd15, 32'h0,         4'd15, 12'h000, 0,0,0, 32'h0};
        vt[12] = '{"disabled",  1,1,0, 12'o6404, 12'o0001, 0, 4'd0,  32'h0,         4'd1,  12'h000, 0,0,0, 32'h0};
        vt[13] = '{"enable",    0,0,0, 12'o0,    12'o0,    1, 4'd15, 32'h8000_0000, 4'd15, 12'h000, 0,0,0, 32'h8000_0000};
        vt[14] = '{"all6417",   1,1,0, 12'o6417, 12'o7070, 0, 4'd0,  32'h0,         4'd1,  12'h777, 0,0,0, 32'h8001_1E38};
        vt[15] = '{"stop_pop",  1,0,1, 12'o0,    12'o0,    1, 4'd1,  32'h0,         4'd1,  12'h000, 0,0,0, 32'h0};
        vt[16] = '{"armwins",   1,1,0, 12'o6412, 12'o0,    1, 4'd3,  32'hC000_0123, 4'd3,  12'h777, 0,0,1, 32'hC000_0123};
        vt[17] = '{"stop_clr",  1,0,1, 12'o0,    12'o0,    1, 4'd3,  32'h0,         4'd3,  12'h000, 0,0,0, 32'h0};

        // reset state
        armraddr = 4'd1;
        #12;
        chk("rst.dev", {20'b0, devtocpu}, 32'h0);
        chk("rst.acc", {31'b0, AC_CLEAR}, 32'h0);
        chk("rst.skip", {31'b0, IO_SKIP}, 32'h0);
        chk("rst.int", {31'b0, INT_RQST}, 32'h0);
        chk("rst.rd1", armrdata, 32'h0);
        @(negedge CLOCK);
        RESET_N = 1'b1;

        // vector table
        for (int i = 0; i < NV; i++) begin
            step(vt[i].cs, vt[i].st, vt[i].sp, 1'b0, vt[i].op, vt[i].ac, vt[i].aw, vt[i].wa, vt[i].wd, vt[i].ra);
            chk({vt[i].nm, ".dev"}, {20'b0, devtocpu}, {20'b0, vt[i].e_dev});
            chk({vt[i].nm, ".acc"}, {31'b0, AC_CLEAR}, {31'b0, vt[i].e_acc});
            chk({vt[i].nm, ".skip"}, {31'b0, IO_SKIP}, {31'b0, vt[i].e_skip});
            chk({vt[i].nm, ".int"}, {31'b0, INT_RQST}, {31'b0, vt[i].e_int});
            chk({vt[i].nm, ".rd"}, armrdata, vt[i].e_rd);
        end

        // fill channel 2 past capacity
        for (int i = 0; i < 17; i++) begin
            iop(12'o6424, 12'(i), 4'd1);
            if (fq.size() < 16) fq.push_back({3'd2, 12'(i)});
            if (i == 16) begin
                chk("fill.acc", {31'b0, AC_CLEAR}, 32'h1);
                chk("fill.full", armrdata, 32'h8010_2000);
                chk("fill.model", armrdata, head_word());
            end
            stop(4'd1);
        end
        stop(4'd4);
        chk("ovf.read", armrdata, OVR ? 32'h2000_0000 : 32'h0);
        iop(12'o6421, 12'o0, 4'd4);
        chk("ovf.skip", {31'b0, IO_SKIP}, {31'b0, OVR});
        stop(4'd4);
        arm_wr(4'd4, 32'h2000_0000, 4'd4);
        chk("ovf.clr", armrdata, 32'h0);

        // pop and push on a full FIFO in one cycle
        step(1, 1, 0, 0, 12'o6424, 12'o7777, 1, 4'd1, 32'h0, 4'd1);
        void'(fq.pop_front());
        fq.push_back({3'd2, 12'o7777});
        chk("fullpp.acc", {31'b0, AC_CLEAR}, 32'h1);
        chk("fullpp.head", armrdata, 32'h8010_2001);
        stop(4'd1);

        // drain and compare each head
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("drain%0d", k), armrdata, head_word());
            arm_wr(4'd1, 32'h0, 4'd1);
            if (fq.size() > 0) void'(fq.pop_front());
        end
        chk("drain.empty", armrdata, 32'h0);

        // pop and push on an empty FIFO: push only
        step(1, 1, 0, 0, 12'o6434, 12'o0042, 1, 4'd1, 32'h0, 4'd1);
        chk("emptypp", armrdata, 32'h8001_3022);
        stop(4'd1);

        // bus init mid-queue
        arm_wr(4'd2, 32'hC000_0ABC, 4'd2);
        chk("bi.setch0", armrdata, 32'hC000_0ABC);
        chk("bi.int", {31'b0, INT_RQST}, 32'h1);
        iop(12'o6404, 12'o0005, 4'd1);
        chk("bi.pre", armrdata, 32'h8002_3022);
        chk("bi.preacc", {31'b0, AC_CLEAR}, 32'h1);
        step(0, 0, 0, 1, 12'o0, 12'o0, 0, 4'd0, 32'h0, 4'd1);
        chk("bi.fifo", armrdata, 32'h0);
        chk("bi.acc", {31'b0, AC_CLEAR}, 32'h0);
        chk("bi.intoff", {31'b0, INT_RQST}, 32'h0);
        step(0, 0, 0, 0, 12'o0, 12'o0, 0, 4'd0, 32'h0, 4'd2);
        chk("bi.reply", armrdata, 32'h8000_0ABC);
        step(0, 0, 0, 0, 12'o0, 12'o0, 0, 4'd0, 32'h0, 4'd15);
        chk("bi.enable", armrdata, 32'h8000_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
